// File: rtl/elpis_uart_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module   : elpis_uart_tx_if
// Purpose  : byte handshake between a producer and the UART TX FIFO
// Revision : 1.0
// ============================================================
interface elpis_uart_tx_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;

  modport master (
    output data_i,
    output valid_i,
    input  ready_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o
  );
endinterface
`default_nettype wire

// File: rtl/elpis_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module   : elpis_uart_tx
// Purpose  : FIFO-buffered 8N1 UART transmitter, registered line output
// Revision : 1.0
// ============================================================
module elpis_uart_tx #(
  parameter int CLK_DIV    = 347,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  elpis_uart_tx_if.slave              bus,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int TMR_W  = $clog2(CLK_DIV);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  logic [7:0]        fifo_mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic              w_push;
  logic              w_pop;
  logic              w_ready;
  logic              w_fifo_empty;
  logic              w_bit_end;
  logic [7:0]        w_head;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tx_q, tx_d;

  // ready depends only on the registered count, so a pop never bypasses a full FIFO
  assign w_ready      = (count_q != CNT_FULL);
  assign w_fifo_empty = (count_q == '0);
  assign w_push       = bus.valid_i && w_ready;
  assign w_head       = fifo_mem_q[rd_ptr_q];
  assign w_bit_end    = (timer_q == TMR_LAST);

  assign bus.ready_o  = w_ready;
  assign fifo_count_o = count_q;
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != S_IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (w_push) begin
      fifo_mem_q[wr_ptr_q] <= bus.data_i;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    w_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop   = 1'b1;
          shreg_d = w_head;
          timer_d = '0;
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          timer_d = '0;
          state_d = S_DATA;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          timer_d = '0;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          timer_d = '0;
          // chain straight into the next frame so no idle gap appears on the line
          if (!w_fifo_empty) begin
            w_pop   = 1'b1;
            shreg_d = w_head;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is a registered image of the current state, one cycle behind it
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_q[idx_q];
      S_STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/elpis_uart_tx.md
ELPIS_UART_TX -- requirements
Module: elpis_uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 347, meaning clock cycles per UART bit (legal range 2..65535).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries (power of two, >=2).
REQ-003 The block SHALL have port wb_clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port wb_rst_i  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port data_i  input  8  byte to transmit.
REQ-006 The block SHALL have port valid_i  input  1  data_i is valid.
REQ-007 The block SHALL have port ready_o  output  1  FIFO can accept a byte this cycle.
REQ-008 The block SHALL have port tx_o  output  1  serial line, idle high; drives mprj_io[6].
REQ-009 The block SHALL have port busy_o  output  1  a frame is being shifted out.
REQ-010 The block SHALL have port fifo_count_o  output  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.

Function
REQ-011 The frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-012 Each bit SHALL be held on tx_o for exactly CLK_DIV cycles; a frame SHALL last exactly 10*CLK_DIV cycles.
REQ-013 tx_o SHALL be driven from a flop, never from combinational logic.
REQ-014 A byte SHALL be accepted on a rising edge where valid_i && ready_o; ready_o SHALL equal (fifo_count_o != FIFO_DEPTH).
REQ-015 A pop in the same cycle as a full FIFO SHALL NOT raise ready_o in that cycle (no full-bypass).
REQ-016 Every byte SHALL pass through the FIFO; there is no direct path from data_i to the shifter.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; simultaneous push and pop SHALL leave fifo_count_o unchanged.
REQ-018 The FSM SHALL have states IDLE, START, DATA, STOP, with a bit timer counting 0..CLK_DIV-1 and a 3-bit data index.
REQ-019 IDLE -> START SHALL occur on the edge where the FIFO is non-empty, popping the head byte into the shift register.
REQ-020 START -> DATA after CLK_DIV cycles; DATA -> STOP after 8 bits; STOP -> START (pop) if FIFO non-empty at stop-bit end, else STOP -> IDLE.
REQ-021 Back-to-back frames SHALL have zero idle cycles between stop bit and next start bit.
REQ-022 Latency: a byte accepted into an empty FIFO with the FSM in IDLE at edge N SHALL drive the start bit on tx_o from edge N+2.
REQ-023 busy_o SHALL be high exactly while the FSM is in START, DATA or STOP.
REQ-024 valid_i while ready_o is low SHALL be ignored; data_i is not sampled.

Reset
REQ-025 On wb_rst_i high, immediately and without a clock: tx_o=1, busy_o=0, fifo_count_o=0, ready_o=1, FSM=IDLE, timer, index and pointers = 0.
REQ-026 Reset mid-frame SHALL abort the frame (tx_o returns high at once) and discard all FIFO contents.
REQ-027 valid_i during reset SHALL NOT store any byte; the first accepted byte is on the first edge after wb_rst_i falls.

Verification
REQ-028 CLK_DIV=4, push 0xA5 once -> tx_o = 0,1,0,1,0,0,1,0,1,1, each value for 4 cycles, start bit at edge N+2, busy_o high 40 cycles.
REQ-029 CLK_DIV=4, push 0x55 then 0x00 on consecutive cycles -> 80 cycles of frames, no high gap between stop of 0x55 and start of 0x00.
REQ-030 CLK_DIV=8, hold valid_i high with 0x01..0x07 -> 5 bytes accepted (1 in shifter, 4 in FIFO), ready_o low, fifo_count_o=4; ready_o rises after first frame ends.
REQ-031 CLK_DIV=4, push 0x00..0x09 paced by ready_o -> bench UART decoder on tx_o receives 0x00..0x09 in order (pointer wrap exercised).
REQ-032 CLK_DIV=4, assert wb_rst_i mid data bit 3 with 3 bytes queued -> tx_o=1, fifo_count_o=0, busy_o=0 before next edge; no further frames after release.
REQ-033 Default CLK_DIV=347 at 40 MHz, push "OK\n" -> testbench UART monitor on mprj_io[6] prints "OK" at 115200 baud.
